// File: rtl/eye_chart_ctrl_if.sv
// Button/frame inputs and active display configuration between the eye-chart
// sequencer (slave) and its environment (master).
interface eye_chart_ctrl_if;
    logic       button1;
    logic       button2;
    logic       button3;
    logic       frame_start;
    logic [2:0] size_level;
    logic [1:0] letter_sel;
    logic       auto_mode;
    logic       cfg_valid;

    modport master (
        output button1, button2, button3, frame_start,
        input  size_level, letter_sel, auto_mode, cfg_valid
    );

    modport slave (
        input  button1, button2, button3, frame_start,
        output size_level, letter_sel, auto_mode, cfg_valid
    );
endinterface

// File: rtl/eye_chart_ctrl.sv
// Eye-chart sequencer: debounces three buttons and steps letter size level/letter
// in manual or auto mode, committing changes only on frame boundaries.
module eye_chart_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned NUM_LEVELS        = 8,
    parameter int unsigned AUTO_DWELL_FRAMES = 60
) (
    input  logic          clk_50M,
    input  logic          rst_n,
    eye_chart_ctrl_if.slave bus
);

    localparam int unsigned CNT_W   = 20;
    localparam int unsigned LVL_W   = 3;
    localparam int unsigned LTR_W   = 2;
    localparam int unsigned FRM_W   = 8;
    localparam int unsigned NUM_BTN = 3;

    localparam logic [CNT_W-1:0] DB_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [FRM_W-1:0] DWELL_MAX = FRM_W'(AUTO_DWELL_FRAMES - 1);

    typedef enum logic [1:0] {
        MANUAL      = 2'd0,
        MANUAL_PEND = 2'd1,
        AUTO        = 2'd2
    } state_t;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] deb;
    logic [NUM_BTN-1:0] press;
    logic [CNT_W-1:0]   db_cnt [NUM_BTN];

    assign raw = {bus.button3, bus.button2, bus.button1};

    // Per-button synchronizer + stability counter; press is a registered rising-edge event
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            press <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    deb[i]    <= ~deb[i];
                    press[i]  <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    logic next_p;
    logic prev_p;
    logic mode_p;

    // Simultaneous next and prev cancel each other
    assign next_p = press[0] & ~press[1];
    assign prev_p = press[1] & ~press[0];
    assign mode_p = press[2];

    state_t           state;
    state_t           state_nxt;
    logic [LVL_W-1:0] pend_level;
    logic [LVL_W-1:0] pend_nxt;
    logic [LVL_W-1:0] size_nxt;
    logic [LTR_W-1:0] letter_nxt;
    logic [FRM_W-1:0] frame_cnt;
    logic [FRM_W-1:0] frame_nxt;
    logic             cfg_nxt;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state          <= MANUAL;
            pend_level     <= '0;
            frame_cnt      <= '0;
            bus.size_level <= '0;
            bus.letter_sel <= '0;
            bus.auto_mode  <= 1'b0;
            bus.cfg_valid  <= 1'b0;
        end else begin
            state          <= state_nxt;
            pend_level     <= pend_nxt;
            frame_cnt      <= frame_nxt;
            bus.size_level <= size_nxt;
            bus.letter_sel <= letter_nxt;
            bus.auto_mode  <= (state_nxt == AUTO);
            bus.cfg_valid  <= cfg_nxt;
        end
    end

    // Mode press always takes priority over level moves and frame commits
    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend_level;
        size_nxt   = bus.size_level;
        letter_nxt = bus.letter_sel;
        frame_nxt  = frame_cnt;
        cfg_nxt    = 1'b0;

        case (state)
            MANUAL, MANUAL_PEND: begin
                if (mode_p) begin
                    state_nxt = AUTO;
                    frame_nxt = '0;
                    pend_nxt  = bus.size_level;
                end else begin
                    if (next_p && (pend_level != LVL_MAX)) begin
                        pend_nxt  = pend_level + LVL_W'(1);
                        state_nxt = MANUAL_PEND;
                    end else if (prev_p && (pend_level != '0)) begin
                        pend_nxt  = pend_level - LVL_W'(1);
                        state_nxt = MANUAL_PEND;
                    end
                    // Commit includes a press landing on the same cycle as the frame
                    if ((state == MANUAL_PEND) && bus.frame_start) begin
                        size_nxt  = pend_nxt;
                        cfg_nxt   = 1'b1;
                        state_nxt = MANUAL;
                    end
                end
            end

            AUTO: begin
                if (mode_p) begin
                    state_nxt = MANUAL;
                    pend_nxt  = bus.size_level;
                end else if (bus.frame_start) begin
                    if (frame_cnt == DWELL_MAX) begin
                        frame_nxt = '0;
                        cfg_nxt   = 1'b1;
                        if (bus.size_level == LVL_MAX) begin
                            size_nxt   = '0;
                            letter_nxt = bus.letter_sel + LTR_W'(1);
                        end else begin
                            size_nxt = bus.size_level + LVL_W'(1);
                        end
                    end else begin
                        frame_nxt = frame_cnt + FRM_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = MANUAL;
            end
        endcase
    end

endmodule

// File: tb/tb_eye_chart_ctrl.sv
// Directed self-checking bench for eye_chart_ctrl with short debounce and dwell.
module tb_eye_chart_ctrl;

    logic clk_50M;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   cfg_pulses;

    eye_chart_ctrl_if bus ();

    eye_chart_ctrl #(
        .DEBOUNCE_CYCLES  (4),
        .NUM_LEVELS       (4),
        .AUTO_DWELL_FRAMES(3)
    ) dut (
        .clk_50M(clk_50M),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    initial cfg_pulses = 0;
    always @(negedge clk_50M) begin
        if (bus.cfg_valid === 1'b1) cfg_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.button1 = 1'b0;
        bus.button2 = 1'b0;
        bus.button3 = 1'b0;
        bus.frame_start = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    // Hold the selected button(s) well beyond debounce, then release and settle
    task automatic press(input logic b1, input logic b2, input logic b3);
        bus.button1 = b1;
        bus.button2 = b2;
        bus.button3 = b3;
        tick(10);
        bus.button1 = 1'b0;
        bus.button2 = 1'b0;
        bus.button3 = 1'b0;
        tick(10);
    endtask

    task automatic frame_pulse();
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.size_level !== 3'd0) begin n_err++; $display("FAIL reset_size: got %0d want 0", bus.size_level); end
        n_cmp++; if (bus.letter_sel !== 2'd0) begin n_err++; $display("FAIL reset_letter: got %0d want 0", bus.letter_sel); end
        n_cmp++; if (bus.auto_mode !== 1'b0) begin n_err++; $display("FAIL reset_auto: got %0b want 0", bus.auto_mode); end
        n_cmp++; if (bus.cfg_valid !== 1'b0) begin n_err++; $display("FAIL reset_cfg: got %0b want 0", bus.cfg_valid); end
    endtask

    task automatic test_single_press();
        int c0;
        do_reset();
        c0 = cfg_pulses;
        press(1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.size_level !== 3'd0) begin n_err++; $display("FAIL press_pre_frame: got %0d want 0", bus.size_level); end
        frame_pulse();
        n_cmp++; if (bus.size_level !== 3'd1) begin n_err++; $display("FAIL press_commit_size: got %0d want 1", bus.size_level); end
        n_cmp++; if (bus.cfg_valid !== 1'b1) begin n_err++; $display("FAIL press_commit_cfg: got %0b want 1", bus.cfg_valid); end
        tick(1);
        n_cmp++; if (bus.cfg_valid !== 1'b0) begin n_err++; $display("FAIL press_cfg_one_cycle: got %0b want 0", bus.cfg_valid); end
        n_cmp++; if (cfg_pulses - c0 !== 1) begin n_err++; $display("FAIL press_cfg_count: got %0d want 1", cfg_pulses - c0); end
    endtask

    task automatic test_glitch();
        int c0;
        do_reset();
        c0 = cfg_pulses;
        bus.button1 = 1'b1;
        tick(2);
        bus.button1 = 1'b0;
        tick(10);
        frame_pulse();
        tick(2);
        n_cmp++; if (bus.size_level !== 3'd0) begin n_err++; $display("FAIL glitch_size: got %0d want 0", bus.size_level); end
        n_cmp++; if (cfg_pulses - c0 !== 0) begin n_err++; $display("FAIL glitch_cfg_count: got %0d want 0", cfg_pulses - c0); end
    endtask

    task automatic test_saturation();
        int c0;
        do_reset();
        repeat (5) press(1'b1, 1'b0, 1'b0);
        frame_pulse();
        n_cmp++; if (bus.size_level !== 3'd3) begin n_err++; $display("FAIL sat_high: got %0d want 3", bus.size_level); end
        repeat (5) press(1'b0, 1'b1, 1'b0);
        frame_pulse();
        n_cmp++; if (bus.size_level !== 3'd0) begin n_err++; $display("FAIL sat_low: got %0d want 0", bus.size_level); end
        tick(2);
        c0 = cfg_pulses;
        press(1'b1, 1'b1, 1'b0);
        frame_pulse();
        tick(2);
        n_cmp++; if (bus.size_level !== 3'd0) begin n_err++; $display("FAIL both_pressed_size: got %0d want 0", bus.size_level); end
        n_cmp++; if (cfg_pulses - c0 !== 0) begin n_err++; $display("FAIL both_pressed_cfg: got %0d want 0", cfg_pulses - c0); end
    endtask

    task automatic test_auto();
        int          c0;
        logic [2:0]  exp_lvl [12];
        exp_lvl = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd0};
        do_reset();
        press(1'b0, 1'b0, 1'b1);
        n_cmp++; if (bus.auto_mode !== 1'b1) begin n_err++; $display("FAIL auto_enter: got %0b want 1", bus.auto_mode); end
        c0 = cfg_pulses;
        for (int k = 0; k < 12; k++) begin
            frame_pulse();
            n_cmp++; if (bus.size_level !== exp_lvl[k]) begin n_err++; $display("FAIL auto_level frame %0d: got %0d want %0d", k + 1, bus.size_level, exp_lvl[k]); end
            n_cmp++; if (bus.cfg_valid !== ((k % 3) == 2)) begin n_err++; $display("FAIL auto_cfg frame %0d: got %0b want %0b", k + 1, bus.cfg_valid, ((k % 3) == 2)); end
            if (k == 10) begin
                n_cmp++; if (bus.letter_sel !== 2'd0) begin n_err++; $display("FAIL auto_letter_pre_wrap: got %0d want 0", bus.letter_sel); end
            end
            tick(2);
        end
        n_cmp++; if (bus.letter_sel !== 2'd1) begin n_err++; $display("FAIL auto_letter_wrap: got %0d want 1", bus.letter_sel); end
        n_cmp++; if (cfg_pulses - c0 !== 4) begin n_err++; $display("FAIL auto_cfg_count: got %0d want 4", cfg_pulses - c0); end
    endtask

    // Continues from test_auto: level 0, letter 1, frame_cnt 0
    task automatic test_mode_coincident();
        int c0;
        frame_pulse();
        tick(2);
        frame_pulse();
        tick(2);
        c0 = cfg_pulses;
        // Press event is registered 6 edges after the raw level rises
        bus.button3 = 1'b1;
        tick(6);
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
        n_cmp++; if (bus.auto_mode !== 1'b0) begin n_err++; $display("FAIL coinc_auto_mode: got %0b want 0", bus.auto_mode); end
        n_cmp++; if (bus.size_level !== 3'd0) begin n_err++; $display("FAIL coinc_no_step: got %0d want 0", bus.size_level); end
        n_cmp++; if (bus.cfg_valid !== 1'b0) begin n_err++; $display("FAIL coinc_cfg: got %0b want 0", bus.cfg_valid); end
        tick(4);
        bus.button3 = 1'b0;
        tick(10);
        n_cmp++; if (cfg_pulses - c0 !== 0) begin n_err++; $display("FAIL coinc_cfg_count: got %0d want 0", cfg_pulses - c0); end
        press(1'b1, 1'b0, 1'b0);
        frame_pulse();
        n_cmp++; if (bus.size_level !== 3'd1) begin n_err++; $display("FAIL coinc_manual_step: got %0d want 1", bus.size_level); end
        n_cmp++; if (bus.letter_sel !== 2'd1) begin n_err++; $display("FAIL coinc_letter_kept: got %0d want 1", bus.letter_sel); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        frame_pulse();
        press(1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.size_level !== 3'd1) begin n_err++; $display("FAIL mid_pending_size: got %0d want 1", bus.size_level); end
        #5;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.size_level !== 3'd0) begin n_err++; $display("FAIL mid_async_size: got %0d want 0", bus.size_level); end
        n_cmp++; if (bus.auto_mode !== 1'b0) begin n_err++; $display("FAIL mid_async_auto: got %0b want 0", bus.auto_mode); end
        n_cmp++; if (bus.letter_sel !== 2'd0) begin n_err++; $display("FAIL mid_async_letter: got %0d want 0", bus.letter_sel); end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        frame_pulse();
        n_cmp++; if (bus.cfg_valid !== 1'b0) begin n_err++; $display("FAIL mid_post_cfg: got %0b want 0", bus.cfg_valid); end
        n_cmp++; if (bus.size_level !== 3'd0) begin n_err++; $display("FAIL mid_post_size: got %0d want 0", bus.size_level); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.button1 = 1'b0;
        bus.button2 = 1'b0;
        bus.button3 = 1'b0;
        bus.frame_start = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_saturation();
        test_auto();
        test_mode_coincident();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
